// File: rtl/rom_prefetch_unit.sv
// Sequential instruction prefetcher: streams ROM words into a small FIFO behind a valid/ready port.
// Optional FETCH_COUNT_EN macro adds a saturating word_count output (pops since last accepted start).
module rom_prefetch_unit #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int ROM_WORDS = 1024
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              err_misalign
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]       word_count
`endif
);

    localparam int BYTES = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] ROM_END    = ADDR_W'(ROM_WORDS * BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic                r_inflight;
    logic                r_discard;
    logic [ADDR_W-1:0]   r_inflight_addr;
    logic [DATA_W-1:0]   r_fifo_data [DEPTH];
    logic [ADDR_W-1:0]   r_fifo_addr [DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_err;

    logic                w_aligned;
    logic                w_start_ok;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic [CNT_W:0]      w_occ;
    logic [CNT_W:0]      w_limit;
    logic [ADDR_W-1:0]   w_pc_inc;

    assign w_aligned  = (start_addr & ALIGN_MASK) == '0;
    assign w_start_ok = start & w_aligned;
    assign w_pop      = out_valid & out_ready;
    // A start flushes the FIFO on the same edge, so the word landing then is dropped too.
    assign w_push     = r_inflight & ~r_discard & ~w_start_ok;

    // count + inflight - pop < DEPTH, rearranged to avoid an unsigned underflow.
    assign w_occ   = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
    assign w_limit = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(w_pop);
    assign w_issue = (r_state == S_FETCH) && (w_occ < w_limit);

    assign w_pc_inc = r_pc + STEP;

    assign rom_en       = w_issue;
    assign rom_addr     = r_pc;
    assign out_valid    = (r_count != '0);
    assign out_data     = r_fifo_data[r_rptr];
    assign out_addr     = r_fifo_addr[r_rptr];
    assign busy         = (r_state == S_FETCH) | r_inflight;
    assign err_misalign = r_err;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (w_start_ok) begin
            w_state_next = S_FETCH;
            w_pc_next    = start_addr;
        end else begin
            if (r_state == S_FETCH && stop) begin
                w_state_next = S_IDLE;
            end
            if (w_issue) begin
                w_pc_next = (w_pc_inc == ROM_END) ? '0 : w_pc_inc;
            end
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_state         <= S_IDLE;
            r_pc            <= '0;
            r_inflight      <= 1'b0;
            r_discard       <= 1'b0;
            r_inflight_addr <= '0;
            r_err           <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_inflight <= w_issue;
            // A read issued in the same cycle as an accepted start belongs to the old stream.
            r_discard  <= w_start_ok;
            r_err      <= start & ~w_aligned;
            if (w_issue) begin
                r_inflight_addr <= r_pc;
            end
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_start_ok) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clka or negedge rsta_n) begin
                if (!rsta_n) begin
                    r_fifo_data[gi] <= '0;
                    r_fifo_addr[gi] <= '0;
                end else if (w_push && r_wptr == PTR_W'(gi)) begin
                    r_fifo_data[gi] <= rom_dout;
                    r_fifo_addr[gi] <= r_inflight_addr;
                end
            end
        end
    endgenerate

`ifdef FETCH_COUNT_EN
    logic [31:0] r_word_count;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_word_count <= '0;
        end else if (w_start_ok) begin
            r_word_count <= '0;
        end else if (w_pop && r_word_count != '1) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end

    assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_rom_prefetch_unit.sv
// Directed bench for rom_prefetch_unit: streaming, backpressure, redirect, wrap, commands, async reset.
// Expected addresses are hand-written; expected data comes from the bench's own ROM contents function.
module tb_rom_prefetch_unit;

    logic        clk = 1'b0;
    logic        rsta_n;
    logic        start;
    logic [31:0] start_addr;
    logic        stop;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_dout = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        busy;
    logic        err_misalign;

    logic        wp_start;
    logic [31:0] wp_start_addr;
    logic        wp_stop;
    logic        wp_rom_en;
    logic [31:0] wp_rom_addr;
    logic [31:0] wp_rom_dout = '0;
    logic        wp_out_valid;
    logic        wp_out_ready;
    logic [31:0] wp_out_data;
    logic [31:0] wp_out_addr;
    logic        wp_busy;
    logic        wp_err;
`ifdef FETCH_COUNT_EN
    logic [31:0] word_count;
    logic [31:0] wp_word_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_en;
    logic [31:0] wrap_exp [4];

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("PASS %s: %0h", tag, obs);
        end
    endtask

    always @(posedge clk) if (rom_en) rom_dout <= romf(rom_addr);
    always @(posedge clk) if (wp_rom_en) wp_rom_dout <= romf(wp_rom_addr);

    rom_prefetch_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .ROM_WORDS(1024)
    ) u_dut (
        .clka(clk), .rsta_n(rsta_n), .start(start), .start_addr(start_addr), .stop(stop),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .err_misalign(err_misalign)
`ifdef FETCH_COUNT_EN
        , .word_count(word_count)
`endif
    );

    rom_prefetch_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .ROM_WORDS(16)
    ) u_wrap (
        .clka(clk), .rsta_n(rsta_n), .start(wp_start), .start_addr(wp_start_addr), .stop(wp_stop),
        .rom_en(wp_rom_en), .rom_addr(wp_rom_addr), .rom_dout(wp_rom_dout),
        .out_valid(wp_out_valid), .out_ready(wp_out_ready), .out_data(wp_out_data),
        .out_addr(wp_out_addr), .busy(wp_busy), .err_misalign(wp_err)
`ifdef FETCH_COUNT_EN
        , .word_count(wp_word_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rsta_n = 1'b0; start = 1'b0; start_addr = '0; stop = 1'b0; out_ready = 1'b0;
        wp_start = 1'b0; wp_start_addr = '0; wp_stop = 1'b0; wp_out_ready = 1'b0;
        wrap_exp = '{32'h38, 32'h3C, 32'h00, 32'h04};
        step();

        @(negedge clk);
        check("rst_rom_en", rom_en, 1'b0);
        check("rst_rom_addr", rom_addr, 32'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_misalign, 1'b0);
        step();
        rsta_n = 1'b1;
        @(negedge clk);
        check("idle_rom_en", rom_en, 1'b0);
        check("idle_busy", busy, 1'b0);
        step();

        // Streaming from 0x10
        start = 1'b1; start_addr = 32'h10; out_ready = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("strm_k1_rom_en", rom_en, 1'b1);
        check("strm_k1_rom_addr", rom_addr, 32'h10);
        check("strm_k1_valid", out_valid, 1'b0);
        check("strm_k1_busy", busy, 1'b1);
        step();
        @(negedge clk);
        check("strm_k2_rom_addr", rom_addr, 32'h14);
        check("strm_k2_valid", out_valid, 1'b0);
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("strm_valid", out_valid, 1'b1);
            check("strm_addr", out_addr, 32'h10 + 32'(4 * i));
            check("strm_data", out_data, romf(32'h10 + 32'(4 * i)));
            step();
        end

        // Backpressure: fresh start at 0x100 with consumer stalled
        start = 1'b1; start_addr = 32'h100; out_ready = 1'b0;
        step();
        start = 1'b0;
        n_en = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rom_en) n_en++;
            step();
        end
        @(negedge clk);
        check("bp_issue_count", 32'(n_en), 32'd4);
        check("bp_rom_en_held", rom_en, 1'b0);
        check("bp_valid", out_valid, 1'b1);
        check("bp_head_addr", out_addr, 32'h100);
        check("bp_head_data", out_data, romf(32'h100));
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bp_drain_valid", out_valid, 1'b1);
            check("bp_drain_addr", out_addr, 32'h100 + 32'(4 * i));
            step();
        end

        // Redirect to 0x200 while the 0x40 read is in flight
        start = 1'b1; start_addr = 32'h40;
        step();
        start = 1'b0;
        @(negedge clk);
        check("rd_issue40_en", rom_en, 1'b1);
        check("rd_issue40_addr", rom_addr, 32'h40);
        step();
        start = 1'b1; start_addr = 32'h200;
        @(negedge clk);
        check("rd_inflight_valid", out_valid, 1'b0);
        step();
        start = 1'b0;
        @(negedge clk);
        check("rd_k1_valid", out_valid, 1'b0);
        check("rd_k1_rom_en", rom_en, 1'b1);
        check("rd_k1_rom_addr", rom_addr, 32'h200);
        step();
        @(negedge clk);
        check("rd_k2_valid", out_valid, 1'b0);
        step();
        @(negedge clk);
        check("rd_k3_valid", out_valid, 1'b1);
        check("rd_k3_addr", out_addr, 32'h200);
        check("rd_k3_data", out_data, romf(32'h200));
        step();
        @(negedge clk);
        check("rd_k4_addr", out_addr, 32'h204);
        step();

        // Misaligned start is rejected, stream continues
        start = 1'b1; start_addr = 32'h22;
        @(negedge clk);
        check("mis_err_pre", err_misalign, 1'b0);
        check("mis_addr0", out_addr, 32'h208);
        step();
        start = 1'b0;
        @(negedge clk);
        check("mis_err_pulse", err_misalign, 1'b1);
        check("mis_addr1", out_addr, 32'h20C);
        step();
        @(negedge clk);
        check("mis_err_clear", err_misalign, 1'b0);
        check("mis_addr2", out_addr, 32'h210);
        step();

        // Start and stop together: start wins
        start = 1'b1; stop = 1'b1; start_addr = 32'h300;
        @(negedge clk);
        check("ss_pre_addr", out_addr, 32'h214);
        step();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        check("ss_k1_rom_en", rom_en, 1'b1);
        check("ss_k1_rom_addr", rom_addr, 32'h300);
        check("ss_k1_valid", out_valid, 1'b0);
        check("ss_k1_busy", busy, 1'b1);
`ifdef FETCH_COUNT_EN
        check("ss_k1_wcount", word_count, 32'd0);
`endif
        step();
        @(negedge clk);
        check("ss_k2_rom_addr", rom_addr, 32'h304);
        step();
        @(negedge clk);
        check("ss_k3_valid", out_valid, 1'b1);
        check("ss_k3_addr", out_addr, 32'h300);
`ifdef FETCH_COUNT_EN
        check("ss_k3_wcount", word_count, 32'd0);
`endif
        step();

        // Stop: buffered and in-flight words still delivered
        stop = 1'b1;
        @(negedge clk);
        check("stop_addr0", out_addr, 32'h304);
`ifdef FETCH_COUNT_EN
        check("stop_wcount", word_count, 32'd1);
`endif
        step();
        stop = 1'b0;
        @(negedge clk);
        check("stop_rom_en0", rom_en, 1'b0);
        check("stop_busy_inflight", busy, 1'b1);
        check("stop_addr1", out_addr, 32'h308);
        step();
        @(negedge clk);
        check("stop_rom_en1", rom_en, 1'b0);
        check("stop_busy_done", busy, 1'b0);
        check("stop_valid_last", out_valid, 1'b1);
        check("stop_addr2", out_addr, 32'h30C);
        step();
        @(negedge clk);
        check("stop_empty", out_valid, 1'b0);
        check("stop_idle_busy", busy, 1'b0);
        step();

        // Asynchronous reset with a full FIFO
        start = 1'b1; start_addr = 32'h10; out_ready = 1'b0;
        step();
        start = 1'b0;
        repeat (6) step();
        check("ar_pre_valid", out_valid, 1'b1);
        #2;
        rsta_n = 1'b0;
        #1;
        check("ar_rom_en", rom_en, 1'b0);
        check("ar_rom_addr", rom_addr, 32'h0);
        check("ar_valid", out_valid, 1'b0);
        check("ar_data", out_data, 32'h0);
        check("ar_addr", out_addr, 32'h0);
        check("ar_busy", busy, 1'b0);
        check("ar_err", err_misalign, 1'b0);
        step();
        rsta_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ar_post_rom_en", rom_en, 1'b0);
            check("ar_post_busy", busy, 1'b0);
            check("ar_post_valid", out_valid, 1'b0);
            step();
        end

        // Wrap: 16-word ROM, start near the top
        wp_start = 1'b1; wp_start_addr = 32'h38; wp_out_ready = 1'b1;
        step();
        wp_start = 1'b0;
        @(negedge clk);
        check("wrap_busy", wp_busy, 1'b1);
        check("wrap_err", wp_err, 1'b0);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wrap_valid", wp_out_valid, 1'b1);
            check("wrap_addr", wp_out_addr, wrap_exp[i]);
            check("wrap_data", wp_out_data, romf(wrap_exp[i]));
            step();
        end
`ifdef FETCH_COUNT_EN
        @(negedge clk);
        check("wrap_wcount", wp_word_count, 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
